// File: rtl/dut_stim_sequencer.sv
// dut_stim_sequencer: FIFO-fed stimulus engine that applies vectors to a DUT, waits SETTLE
// cycles, and folds each captured y into a 32-bit signature. Define DUT_STIM_SEQUENCER_COMPARE_EN for exp_sig/mismatch.
module dut_stim_sequencer #(
  parameter int IN_W   = 66,
  parameter int OUT_W  = 191,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic [31:0]      signature,
  output logic [7:0]       vec_count,
`ifdef DUT_STIM_SEQUENCER_COMPARE_EN
  input  logic [31:0]      exp_sig,
  output logic             mismatch,
`endif
  output logic [2:0]       state_dbg
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NCH = (OUT_W + 31) / 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Handshake: a vector is transferred on every rising edge where vec_valid && vec_ready;
  // vec_valid may be raised in any state and vec_ready depends only on FIFO occupancy.
  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, empty, full;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign vec_ready = !full;
  assign push      = vec_valid && vec_ready;
  assign pop       = (state_q == S_APPLY);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= vec_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Zero-extend y to whole 32-bit words and XOR the words together.
  logic [NCH*32-1:0] out_ext;
  logic [31:0]       fold_val, sig_next;
  logic [CW-1:0]     settle_cnt;

  assign out_ext = (NCH*32)'(dut_out);

  always_comb begin
    fold_val = '0;
    for (int i = 0; i < NCH; i++) fold_val = fold_val ^ out_ext[i*32 +: 32];
  end

  assign sig_next = {signature[30:0],
                     signature[31] ^ signature[21] ^ signature[1] ^ signature[0]} ^ fold_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = empty ? S_DONE : S_APPLY;
      S_APPLY:   state_d = S_SETTLE;
      S_SETTLE:  if (settle_cnt == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = empty ? S_DONE : S_APPLY;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in     <= '0;
      settle_cnt <= '0;
      signature  <= 32'h0000_0001;
      vec_count  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            signature <= 32'h0000_0001;
            vec_count <= '0;
          end
        end
        S_APPLY: begin
          dut_in     <= mem[rd_ptr];
          settle_cnt <= CW'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        S_CAPTURE: begin
          signature <= sig_next;
          if (vec_count != 8'hFF) vec_count <= vec_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DUT_STIM_SEQUENCER_COMPARE_EN
  // Signature is already final (and held) during DONE, so it is the value compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              mismatch <= 1'b0;
    else if (state_q == S_IDLE && start)  mismatch <= 1'b0;
    else if (state_q == S_DONE)           mismatch <= (signature != exp_sig);
  end
`endif

endmodule

// File: tb/tb_dut_stim_sequencer.sv
// tb_dut_stim_sequencer: random vector runs checked against a queue-based signature model,
// plus directed reset, full-FIFO, empty-run and mid-run reset cases.
module tb_dut_stim_sequencer;
  localparam int IN_W   = 66;
  localparam int OUT_W  = 191;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  vec_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [31:0]      signature;
  logic [7:0]       vec_count;
  logic [2:0]       state_dbg;
  logic [31:0]      exp_sig;
  logic             mismatch;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int done_pulses = 0;
  int mode       = 0;

  logic [IN_W-1:0] exp_q[$];
  logic [IN_W-1:0] last_applied;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_pulses++;

  // Stand-in for the fuzz DUT: y as a pure function of the applied input.
  function automatic logic [OUT_W-1:0] fake_dut(input logic [IN_W-1:0] v, input int m);
    case (m)
      0:       return '0;
      1:       return '1;
      default: return {v, ~v, v[58:0]};
    endcase
  endfunction

  assign dut_out = fake_dut(dut_in, mode);

  dut_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .signature (signature),
    .vec_count (vec_count),
`ifdef DUT_STIM_SEQUENCER_COMPARE_EN
    .exp_sig   (exp_sig),
    .mismatch  (mismatch),
`endif
    .state_dbg (state_dbg)
  );

`ifndef DUT_STIM_SEQUENCER_COMPARE_EN
  assign mismatch = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [31:0] fold_ref(input logic [OUT_W-1:0] y);
    logic [31:0] f = '0;
    for (int b = 0; b < OUT_W; b++) f[b % 32] = f[b % 32] ^ y[b];
    return f;
  endfunction

  function automatic logic [31:0] sig_ref(input logic [31:0] s, input logic [OUT_W-1:0] y);
    logic fb = ^(s & 32'h8020_0003);
    return ((s << 1) | {31'b0, fb}) ^ fold_ref(y);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_vec(input logic [IN_W-1:0] v);
    bit acc;
    int budget = 50;
    vec_valid = 1'b1;
    vec_data  = v;
    do begin
      acc = vec_ready;
      tick();
      budget--;
    end while (!acc && budget > 0);
    vec_valid = 1'b0;
    check("push_accepted", 128'(acc), 128'(1));
    if (acc) exp_q.push_back(v);
  endtask

  // Start a run; optionally push extra vectors and re-pulse start while it is busy.
  // exp_sel: 0 -> exp_sig = model, 1 -> model^1, 2 -> zero.
  task automatic run(input int extra, input bit poke, input int exp_sel);
    int c0, n, budget, p0;
    bit had_vec;
    logic [31:0] m_sig;
    logic [7:0]  m_cnt;
    logic        m_mis;
    p0 = done_pulses;
    had_vec = (exp_q.size() > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    if (had_vec) begin
      tick();
      check("apply_latency", 128'(dut_in), 128'(exp_q[0]));
    end
    for (int j = 0; j < extra; j++) push_vec(rand_vec());
    if (poke && had_vec) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = exp_q.size();
    m_sig = 32'h1;
    m_cnt = 8'd0;
    while (exp_q.size() > 0) begin
      last_applied = exp_q.pop_front();
      m_sig = sig_ref(m_sig, fake_dut(last_applied, mode));
      if (m_cnt != 8'hFF) m_cnt++;
    end
    case (exp_sel)
      0:       exp_sig = m_sig;
      1:       exp_sig = m_sig ^ 32'h1;
      default: exp_sig = 32'h0;
    endcase
    m_mis = (exp_sig != m_sig);
    budget = 400;
    while (done !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check("done_seen", 128'(done), 128'(1));
    check("run_latency", 128'(cyc - c0), 128'(n * (SETTLE + 2)));
    check("signature", 128'(signature), 128'(m_sig));
    check("vec_count", 128'(vec_count), 128'(m_cnt));
    check("dut_in_final", 128'(dut_in), 128'(last_applied));
    tick();
    check("done_single", 128'(done), 128'(0));
    check("busy_after", 128'(busy), 128'(0));
    check("sig_held", 128'(signature), 128'(m_sig));
    check("done_pulses", 128'(done_pulses - p0), 128'(1));
`ifdef DUT_STIM_SEQUENCER_COMPARE_EN
    check("mismatch", 128'(mismatch), 128'(m_mis));
`else
    if (m_mis) exp_sig = '0;
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dut_in"}, 128'(dut_in), 128'(0));
    check({tag, "_sig"},    128'(signature), 128'(32'h1));
    check({tag, "_cnt"},    128'(vec_count), 128'(0));
    check({tag, "_busy"},   128'(busy), 128'(0));
    check({tag, "_done"},   128'(done), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    vec_valid = 1'b0;
    vec_data = '0;
    start = 1'b0;
    exp_sig = '0;
    last_applied = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_values("reset");
    check("reset_ready", 128'(vec_ready), 128'(1));
    check("reset_mismatch", 128'(mismatch), 128'(0));

    // single vector, y = 0
    mode = 0;
    push_vec(66'h1);
    run(0, 0, 0);
    check("sig_one_zero", 128'(signature), 128'(32'h0000_0003));
    check("cnt_one_zero", 128'(vec_count), 128'(1));

    // single vector, y = all ones
    mode = 1;
    push_vec(66'h1);
    run(0, 0, 0);
    check("sig_one_ones", 128'(signature), 128'(32'h8000_0003));

    // fill the FIFO and offer a 17th vector
    mode = 2;
    for (int i = 0; i < DEPTH; i++) push_vec(rand_vec());
    check("full_ready", 128'(vec_ready), 128'(0));
    vec_valid = 1'b1;
    vec_data  = rand_vec();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold", 128'(vec_ready), 128'(0));
    end
    vec_valid = 1'b0;
    run(0, 1, 0);
    check("cnt_full", 128'(vec_count), 128'(16));

    // empty start
    run(0, 0, 0);
    check("cnt_empty", 128'(vec_count), 128'(0));
    check("sig_empty", 128'(signature), 128'(32'h1));

    // reset during SETTLE of the 3rd of 5 vectors
    for (int i = 0; i < 5; i++) push_vec(rand_vec());
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * (SETTLE + 2) + 1) tick();
    check("pre_reset_busy", 128'(busy), 128'(1));
    check("pre_reset_state", 128'(state_dbg), 128'(2));
    rst = 1'b1;
    #1;
    check_reset_values("midrun");
    tick();
    rst = 1'b0;
    exp_q.delete();
    last_applied = '0;
    tick();
    check("post_reset_ready", 128'(vec_ready), 128'(1));
    run(0, 0, 0);
    check("post_reset_cnt", 128'(vec_count), 128'(0));

    // compare feature
    mode = 0;
    push_vec(66'h1);
    run(0, 0, 0);
    push_vec(66'h1);
    run(0, 0, 2);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      int nv;
      nv   = $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < nv; i++) push_vec(rand_vec());
      run((nv >= 2) ? $urandom_range(0, 2) : 0, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/dut_stim_sequencer.md
Name: dut_stim_sequencer

Overview:
- Hardware replacement for the fixed-delay stimulus loop that drives the fuzz `top` DUT.
- Buffers input vectors in a FIFO and applies them to the DUT input bus ({wire0, wire1, wire2, wire3} concatenated) one at a time.
- Waits a programmable settle time, captures the DUT `y` output, and folds each capture into a 32-bit signature.
- Runs are compared by signature instead of per-cycle `$strobe` dumps.

Parameters:
IN_W, 66, DUT input bus width (3+20+21+22)
OUT_W, 191, DUT output width (y[190:0])
DEPTH, 16, vector FIFO entries (power of two, >=2)
SETTLE, 1, cycles between applying a vector and capturing y (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
vec_valid  input  1  load handshake: vec_data valid
vec_ready  output  1  load handshake: FIFO can accept
vec_data  input  IN_W  vector to enqueue
start  input  1  begin run (sampled only in IDLE)
busy  output  1  high in APPLY/SETTLE/CAPTURE
done  output  1  one-cycle pulse at end of run
dut_in  output  IN_W  registered drive to DUT inputs
dut_out  input  OUT_W  DUT y
signature  output  32  running signature
vec_count  output  8  vectors captured this run, saturates at 255

Behaviour:
- Reset (async, immediate) values:
  - State IDLE; FIFO empty.
  - dut_in=0, signature=32'h0000_0001, vec_count=0, done=0, busy=0.
  - vec_ready=1 once reset deasserts.
- Load:
  - Push when vec_valid && vec_ready; vec_ready = !full. Loading is legal in every state.
  - Push and pop in the same cycle leaves the occupancy unchanged.
  - A push while full cannot occur because ready is low.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE.
  - IDLE:
    - start with FIFO non-empty -> APPLY; signature<=32'h1, vec_count<=0.
    - start with FIFO empty -> DONE; signature and vec_count are reset the same way.
    - start is ignored in any state other than IDLE.
  - APPLY (1 cycle): pop FIFO head; dut_in<=head at the clock edge; load settle counter with SETTLE-1 -> SETTLE.
  - SETTLE: decrement counter; when the counter is 0 -> CAPTURE. Duration is exactly SETTLE cycles.
  - CAPTURE (1 cycle):
    - signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold(dut_out).
    - vec_count <= vec_count+1 (saturating at 255).
    - FIFO non-empty -> APPLY, else -> DONE.
  - DONE: done=1 for this single cycle -> IDLE.
- fold(dut_out): zero-extend to a multiple of 32 bits, then XOR all 32-bit chunks.
- Per-vector period is SETTLE+2 cycles; dut_in holds its value between vectors and after the run.
- Vectors pushed during a run are consumed by the same run if they arrive before the FIFO empties at a CAPTURE decision.
- signature and vec_count are held stable from DONE until the next accepted start.
- Reset asserted mid-run aborts immediately to the reset values; FIFO contents are discarded.

Optional Feature:
- Macro: DUT_STIM_SEQUENCER_COMPARE_EN.
- When defined:
  - Adds input exp_sig[31:0] and output mismatch (1 bit).
  - mismatch is registered in the DONE cycle as (next signature value != exp_sig), i.e. compared against the final run signature.
  - mismatch holds until the next accepted start or reset; reset value is 0.
- When undefined: neither port exists and no comparison logic is built.

Test Plan:
- Reset then idle -> dut_in=0, signature=32'h00000001, vec_count=0, vec_ready=1, busy=0, done=0.
- SETTLE=1, push one vector 66'h1, dut_out tied to 0, pulse start:
  - dut_in=66'h1 one cycle after start is accepted.
  - Capture 3 cycles after APPLY entry.
  - signature=32'h00000003, vec_count=1, done pulses once.
- Same as above but dut_out = all ones -> signature=32'h80000003.
- Push 16 vectors -> vec_ready=0 after the 16th. A 17th vec_valid is not accepted. Start -> 16 captures, vec_count=16, dut_in ends at the 16th vector.
- start with FIFO empty -> done one cycle after start, vec_count=0, signature=32'h1. start pulsed while busy -> no effect on the run.
- Assert rst during SETTLE of the 3rd of 5 vectors -> all outputs return to their reset values immediately; FIFO is empty; a new start goes to DONE with no captures.
- COMPARE_EN defined: exp_sig=32'h00000003 with the single-vector zero case -> mismatch=0; exp_sig=32'h0 -> mismatch=1.
